// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, variable step, clear/load,
// wrap or saturate at the limits, a terminal-count pulse and a sticky overflow flag.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2**WIDTH,
    parameter int STEP_W   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              upDown,
    input  logic [STEP_W-1:0] step,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovf
);

    // One bit wider than the larger operand, so count + step and
    // count + MODULUS never truncate before the limit compare.
    localparam int CW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MODULUS - 1);
    localparam logic [CW-1:0] MOD_C = CW'(MODULUS);

    logic [CW-1:0]    step_ext;
    logic [CW-1:0]    s_eff;
    logic [CW-1:0]    cnt_ext;
    logic [CW-1:0]    load_ext;
    logic [CW-1:0]    up_sum;
    logic [CW-1:0]    down_wrap;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             boundary;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        step_ext     = CW'(step);
        cnt_ext      = CW'(count);
        load_ext     = CW'(load_value);
        s_eff        = (step_ext > MAX_C) ? MAX_C : step_ext;
        up_sum       = cnt_ext + s_eff;
        down_wrap    = cnt_ext + MOD_C - s_eff;
        load_clamped = (load_ext > MAX_C) ? WIDTH'(MAX_C) : load_value;
        next_count   = count;
        boundary     = 1'b0;

        if (upDown) begin
            if (up_sum <= MAX_C) begin
                next_count = WIDTH'(up_sum);
            end else begin
                boundary   = 1'b1;
                next_count = SATURATE ? WIDTH'(MAX_C) : WIDTH'(up_sum - MOD_C);
            end
        end else begin
            if (s_eff <= cnt_ext) begin
                next_count = WIDTH'(cnt_ext - s_eff);
            end else begin
                boundary   = 1'b1;
                next_count = SATURATE ? '0 : WIDTH'(down_wrap);
            end
        end
    end

    // Priority on each edge: clear, then load, then enabled counting.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (en) begin
            count <= next_count;
            tc    <= boundary;
            if (boundary) begin
                ovf <= 1'b1;
            end
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus stream
// (wrap mod 10, saturate mod 10, wrap mod 2) and are checked against an arithmetic model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       upDown = 1'b1;
    logic [1:0] step = 2'd0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] cnt_w, cnt_s, cnt_2;
    logic       tc_w, tc_s, tc_2;
    logic       ovf_w, ovf_s, ovf_2;

    logic [3:0] d_cnt [3];
    logic       d_tc  [3];
    logic       d_ovf [3];

    int total = 0;
    int bad   = 0;

    // Reference model: one entry per instance.
    int mod_c [3] = '{10, 10, 2};
    bit sat_c [3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [3];
    bit m_tc  [3];
    bit m_ovf [3];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .STEP_W(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .upDown(upDown), .step(step), .clear(clear),
        .load(load), .load_value(load_value), .count(cnt_w), .tc(tc_w), .ovf(ovf_w));

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .STEP_W(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .upDown(upDown), .step(step), .clear(clear),
        .load(load), .load_value(load_value), .count(cnt_s), .tc(tc_s), .ovf(ovf_s));

    updown_counter_param #(.WIDTH(4), .MODULUS(2), .STEP_W(2), .SATURATE(1'b0)) u_m2 (
        .clk(clk), .reset(reset), .en(en), .upDown(upDown), .step(step), .clear(clear),
        .load(load), .load_value(load_value), .count(cnt_2), .tc(tc_2), .ovf(ovf_2));

    assign d_cnt[0] = cnt_w;  assign d_tc[0] = tc_w;  assign d_ovf[0] = ovf_w;
    assign d_cnt[1] = cnt_s;  assign d_tc[1] = tc_s;  assign d_ovf[1] = ovf_s;
    assign d_cnt[2] = cnt_2;  assign d_tc[2] = tc_2;  assign d_ovf[2] = ovf_2;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Plain integer arithmetic: wrap is a modulo, a boundary is leaving [0, mod-1].
    task automatic model_edge();
        int s, raw;
        bit hit;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_cnt[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end else if (load) begin
                m_cnt[i] = (int'(load_value) > mod_c[i] - 1) ? mod_c[i] - 1 : int'(load_value);
                m_tc[i]  = 1'b0;
            end else if (en) begin
                s   = (int'(step) > mod_c[i] - 1) ? mod_c[i] - 1 : int'(step);
                raw = upDown ? m_cnt[i] + s : m_cnt[i] - s;
                hit = (raw < 0) || (raw >= mod_c[i]);
                if (hit && sat_c[i])
                    m_cnt[i] = upDown ? mod_c[i] - 1 : 0;
                else
                    m_cnt[i] = (raw + mod_c[i]) % mod_c[i];
                m_tc[i]  = hit;
                m_ovf[i] = m_ovf[i] | hit;
            end else begin
                m_tc[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (cnt_w !== 4'd0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin bad++;
            $display("FAIL reset_hold: got cnt=%0d tc=%0b ovf=%0b want 0/0/0", cnt_w, tc_w, ovf_w); end
        reset = 1'b0; load = 1'b1; load_value = 4'd7;
        tick();
        load = 1'b0;
        total++; if (cnt_w !== 4'd7) begin bad++;
            $display("FAIL reset_preload: got %0d want 7", cnt_w); end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (cnt_w !== 4'd0 || tc_w !== 1'b0 || ovf_w !== 1'b0) begin bad++;
            $display("FAIL reset_async: got cnt=%0d tc=%0b ovf=%0b want 0/0/0", cnt_w, tc_w, ovf_w); end
        en = 1'b1; upDown = 1'b1; step = 2'd1;
        #2;
        reset = 1'b0;
        tick();
        total++; if (cnt_w !== 4'd1) begin bad++;
            $display("FAIL reset_release: got %0d want 1", cnt_w); end
    endtask

    task automatic test_wrap_up();
        load = 1'b1; load_value = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; upDown = 1'b1; step = 2'd3;
        tick();
        total++; if (cnt_w !== 4'd1 || tc_w !== 1'b1 || ovf_w !== 1'b1) begin bad++;
            $display("FAIL wrap_up: got cnt=%0d tc=%0b ovf=%0b want 1/1/1", cnt_w, tc_w, ovf_w); end
        step = 2'd1;
        tick();
        total++; if (cnt_w !== 4'd2 || tc_w !== 1'b0 || ovf_w !== 1'b1) begin bad++;
            $display("FAIL wrap_up_next: got cnt=%0d tc=%0b ovf=%0b want 2/0/1", cnt_w, tc_w, ovf_w); end
    endtask

    task automatic test_wrap_down();
        load = 1'b1; load_value = 4'd1;
        tick();
        load = 1'b0; en = 1'b1; upDown = 1'b0; step = 2'd2;
        tick();
        total++; if (cnt_w !== 4'd9 || tc_w !== 1'b1) begin bad++;
            $display("FAIL wrap_down: got cnt=%0d tc=%0b want 9/1", cnt_w, tc_w); end
        load = 1'b1; load_value = 4'd2;
        tick();
        load = 1'b0;
        tick();
        total++; if (cnt_w !== 4'd0 || tc_w !== 1'b0) begin bad++;
            $display("FAIL land_zero: got cnt=%0d tc=%0b want 0/0", cnt_w, tc_w); end
    endtask

    task automatic test_saturate();
        load = 1'b1; load_value = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; upDown = 1'b1; step = 2'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (cnt_s !== 4'd9 || tc_s !== 1'b1 || ovf_s !== 1'b1) begin bad++;
                $display("FAIL sat_top[%0d]: got cnt=%0d tc=%0b ovf=%0b want 9/1/1", k, cnt_s, tc_s, ovf_s); end
        end
        load = 1'b1; load_value = 4'd0;
        tick();
        total++; if (tc_s !== 1'b0) begin bad++;
            $display("FAIL sat_load_tc: got %0b want 0", tc_s); end
        load = 1'b0; upDown = 1'b0;
        tick();
        total++; if (cnt_s !== 4'd0 || tc_s !== 1'b1) begin bad++;
            $display("FAIL sat_bottom: got cnt=%0d tc=%0b want 0/1", cnt_s, tc_s); end
    endtask

    task automatic test_priority();
        clear = 1'b1; load = 1'b1; en = 1'b1; load_value = 4'd5;
        tick();
        total++; if (cnt_w !== 4'd0 || ovf_w !== 1'b0 || cnt_s !== 4'd0 || ovf_s !== 1'b0) begin bad++;
            $display("FAIL prio_clear: got w=%0d/%0b s=%0d/%0b want 0/0 0/0", cnt_w, ovf_w, cnt_s, ovf_s); end
        clear = 1'b0; load_value = 4'd15;
        tick();
        total++; if (cnt_w !== 4'd9 || cnt_2 !== 4'd1) begin bad++;
            $display("FAIL load_clamp: got w=%0d m2=%0d want 9 1", cnt_w, cnt_2); end
        load = 1'b0; en = 1'b0; upDown = 1'b1; step = 2'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (cnt_w !== 4'd9 || tc_w !== 1'b0) begin bad++;
                $display("FAIL en_low_hold[%0d]: got cnt=%0d tc=%0b want 9/0", k, cnt_w, tc_w); end
        end
    endtask

    task automatic test_clamp_step0();
        clear = 1'b1;
        tick();
        clear = 1'b0; en = 1'b1; upDown = 1'b1; step = 2'd3;
        tick();
        total++; if (cnt_2 !== 4'd1 || tc_2 !== 1'b0) begin bad++;
            $display("FAIL clamp_first: got cnt=%0d tc=%0b want 1/0", cnt_2, tc_2); end
        tick();
        total++; if (cnt_2 !== 4'd0 || tc_2 !== 1'b1 || ovf_2 !== 1'b1) begin bad++;
            $display("FAIL clamp_wrap: got cnt=%0d tc=%0b ovf=%0b want 0/1/1", cnt_2, tc_2, ovf_2); end
        step = 2'd0;
        tick();
        total++; if (cnt_w !== 4'd6 || tc_w !== 1'b0) begin bad++;
            $display("FAIL step_zero: got cnt=%0d tc=%0b want 6/0", cnt_w, tc_w); end
    endtask

    // Random stream with back-to-back direction changes and occasional async reset pulses.
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en         = ($urandom % 4) != 0;
            upDown     = 1'($urandom);
            step       = 2'($urandom);
            clear      = ($urandom % 25) == 0;
            load       = ($urandom % 10) == 0;
            load_value = 4'($urandom);
            if (($urandom % 60) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                reset = 1'b0;
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (d_cnt[i] !== 4'(m_cnt[i]) || d_tc[i] !== m_tc[i] || d_ovf[i] !== m_ovf[i]) begin
                    bad++;
                    $display("FAIL random[%0d] dut%0d: got cnt=%0d tc=%0b ovf=%0b want %0d/%0b/%0b",
                             n, i, d_cnt[i], d_tc[i], d_ovf[i], m_cnt[i], m_tc[i], m_ovf[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_priority();
        test_clamp_step0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
